frame_scheduler: RTL

Top-level render sequencer for the 160x120 VGA game screen. It generates the frame tick, runs the screen clear, and handshakes once per frame with game logic for the position and bullet-grid update. It then scans every pixel address into the colour datapath and drives the VGA adapter write strobe. It sits between the game-state logic and the colour datapath/vga_adapter.

---
 rtl/render_pkg.sv | 27 ++
 rtl/frame_scheduler_if.sv | 33 +++
 rtl/frame_scheduler_pixel_scanner.sv | 58 +++++
 rtl/frame_scheduler.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared definitions for the render sequencer: FSM state encoding,
// screen geometry defaults and colour constants used by the datapath.
package render_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DRAW   = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  // The raster scanner is shared between the clear pass and the draw pass.
  function automatic logic is_scan_state(input state_t s);
    return (s == S_CLEAR) || (s == S_DRAW);
  endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Bundle of game-logic handshake and datapath/VGA signals around the scheduler.
// master = scheduler side, slave = game logic / colour datapath side.
interface frame_scheduler_if;
  import render_pkg::*;

  logic           start_game;
  logic           game_over;
  logic           upd_ack;
  logic           upd_req;
  logic           clear_en;
  logic           draw_en;
  logic [X_W-1:0] scan_x;
  logic [Y_W-1:0] scan_y;
  logic           plot;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic           frame_done;
  logic           overrun;
  logic           upd_timeout;
  logic [2:0]     state;

  modport master (
    input  start_game, game_over, upd_ack,
    output upd_req, clear_en, draw_en, scan_x, scan_y, plot, plot_x, plot_y,
           frame_done, overrun, upd_timeout, state
  );

  modport slave (
    output start_game, game_over, upd_ack,
    input  upd_req, clear_en, draw_en, scan_x, scan_y, plot, plot_x, plot_y,
           frame_done, overrun, upd_timeout, state
  );
endinterface

// File: rtl/frame_scheduler_pixel_scanner.sv
// Raster address generator: walks (0,0)..(W-1,H-1) one pixel per enabled cycle
// and delays the address/strobe by one cycle to line up with registered colour.
module pixel_scanner
  import render_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           en,
  input  logic           restart,
  output logic [X_W-1:0] scan_x,
  output logic [Y_W-1:0] scan_y,
  output logic           last_pixel,
  output logic           plot,
  output logic [X_W-1:0] plot_x,
  output logic [Y_W-1:0] plot_y
);

  logic x_end;
  logic y_end;

  assign x_end      = (scan_x == X_W'(SCREEN_W - 1));
  assign y_end      = (scan_y == Y_W'(SCREEN_H - 1));
  assign last_pixel = en & x_end & y_end;

  // Wrapping after the last pixel leaves the counter at (0,0) for the next pass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (restart) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (en) begin
      if (x_end) begin
        scan_x <= '0;
        scan_y <= y_end ? '0 : scan_y + 1'b1;
      end else begin
        scan_x <= scan_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot   <= 1'b0;
      plot_x <= '0;
      plot_y <= '0;
    end else begin
      plot   <= en;
      plot_x <= scan_x;
      plot_y <= scan_y;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame render sequencer: frame tick, screen clear, game-state update
// handshake, then a full pixel scan into the colour datapath / VGA adapter.
module frame_scheduler
  import render_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int FRAME_HZ    = 60,
  parameter int SCREEN_W    = SCREEN_W_DEFAULT,
  parameter int SCREEN_H    = SCREEN_H_DEFAULT,
  parameter int ACK_TIMEOUT = 255
) (
  input logic               clk,
  input logic               resetn,
  frame_scheduler_if.master bus
);

  localparam int DIV   = CLK_HZ / FRAME_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  state_t           state_q;
  state_t           state_d;
  logic             start_q;
  logic             start_rise;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             tick_live;
  logic             tick_pend;
  logic [TO_W-1:0]  to_cnt;
  logic             consume;
  logic             timeout_hit;
  logic             overrun_q;
  logic             timeout_q;
  logic             frame_done_q;
  logic             scan_active;
  logic             last_pixel;
  logic [X_W-1:0]   scan_x;
  logic [Y_W-1:0]   scan_y;
  logic             plot;
  logic [X_W-1:0]   plot_x;
  logic [Y_W-1:0]   plot_y;

  assign start_rise  = bus.start_game & ~start_q;
  assign tick        = (div_cnt == DIV_W'(DIV - 1));
  // Idle and game-over screens have no frames to schedule, so ticks there are dropped.
  assign tick_live   = tick && (state_q != S_IDLE) && (state_q != S_OVER);
  assign scan_active = is_scan_state(state_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      start_q <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      start_q <= bus.start_game;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    consume     = 1'b0;
    timeout_hit = 1'b0;
    if (start_rise) begin
      state_d = S_CLEAR;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: state_d = state_q;
        S_CLEAR: if (last_pixel) state_d = S_WAIT;
        S_WAIT: begin
          if (bus.game_over) begin
            state_d = S_OVER;
          end else if (tick_pend) begin
            state_d = S_UPDATE;
            consume = 1'b1;
          end
        end
        S_UPDATE: begin
          if (bus.upd_ack) begin
            state_d = S_DRAW;
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            state_d     = S_DRAW;
            timeout_hit = 1'b1;
          end
        end
        S_DRAW: if (last_pixel) state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A tick landing on the very cycle WAIT consumes the old one stays pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_pend    <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      frame_done_q <= 1'b0;
      to_cnt       <= '0;
    end else begin
      frame_done_q <= (state_q == S_DRAW) && last_pixel && !start_rise;
      to_cnt       <= (state_q == S_UPDATE) ? to_cnt + 1'b1 : '0;
      if (start_rise) begin
        tick_pend <= 1'b0;
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        if (tick_live)    tick_pend <= 1'b1;
        else if (consume) tick_pend <= 1'b0;
        if (tick_live && tick_pend && !consume) overrun_q <= 1'b1;
        if (timeout_hit) timeout_q <= 1'b1;
      end
    end
  end

  pixel_scanner #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_scanner (
    .clk       (clk),
    .resetn    (resetn),
    .en        (scan_active),
    .restart   (start_rise),
    .scan_x    (scan_x),
    .scan_y    (scan_y),
    .last_pixel(last_pixel),
    .plot      (plot),
    .plot_x    (plot_x),
    .plot_y    (plot_y)
  );

  assign bus.upd_req     = (state_q == S_UPDATE);
  assign bus.clear_en    = (state_q == S_CLEAR);
  assign bus.draw_en     = (state_q == S_DRAW);
  assign bus.scan_x      = scan_x;
  assign bus.scan_y      = scan_y;
  assign bus.plot        = plot;
  assign bus.plot_x      = plot_x;
  assign bus.plot_y      = plot_y;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;
  assign bus.upd_timeout = timeout_q;
  assign bus.state       = state_q;

endmodule
